// File: rtl/cr_isf_flow_ctl_if.sv
`default_nettype none
// ============================================================================
// Module : cr_isf_flow_ctl_if
// Brief  : AXI4-Stream beat interface used on both sides of the ISF flow
//          sequencer (FIFO read side and outbound port).
//   tvalid / tready : handshake
//   tdata  [DATA_W] : beat payload
//   tuser  [USER_W] : sideband
//   tlast           : packet end marker
//   master modport drives the beat, slave modport drives tready.
// Rev    : 1.0  initial release
// ============================================================================
interface cr_isf_flow_ctl_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;

  modport master (output tvalid, tdata, tuser, tlast, input  tready);
  modport slave  (input  tvalid, tdata, tuser, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/cr_isf_flow_ctl.sv
`default_nettype none
// ============================================================================
// Module : cr_isf_flow_ctl
// Brief  : Flow sequencer between the ISF FIFO read side and the outbound
//          AXI4-S port. Passes beats through, halts on a debug trigger or
//          software halt, releases programmed beat counts in single-step
//          mode, captures stepped beats and runs the stall watchdog.
// Ports  :
//   clk, rst_n        core clock, asynchronous active-low reset
//   cfg_mode[1:0]     0=PASS 1=STEP 2/3=HALT (level)
//   cfg_trig_halt     halt on trig_hit while in PASS
//   resume_stb        leave trigger-induced HALT (cfg_mode==0)
//   ss_stb, ss_beats  load single-step credit (0 treated as 1)
//   trig_hit          debug trigger match pulse
//   stall_limit       watchdog threshold, 0 disables
//   stall_clr         clear stall_sts
//   in_if  (slave)    FIFO-side beat stream
//   out_if (master)   outbound beat stream, combinational from in_if
//   ss_cap_*          last beat released in STEP_RUN, ss_cap_valid flags it
//   ss_busy           step credit non-zero
//   halted_trig       HALT was entered via the trigger (sticky)
//   state             0=PASS 1=HALT 2=STEP_WAIT 3=STEP_RUN
//   stall_event       one-cycle pulse when the stall count reaches the limit
//   stall_sts         sticky stall flag
// Rev    : 1.0  initial release
// ============================================================================
module cr_isf_flow_ctl #(
  parameter int DATA_W   = 64,
  parameter int USER_W   = 8,
  parameter int SS_CNT_W = 16,
  parameter int STALL_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          cfg_mode,
  input  logic                cfg_trig_halt,
  input  logic                resume_stb,
  input  logic                ss_stb,
  input  logic [SS_CNT_W-1:0] ss_beats,
  input  logic                trig_hit,
  input  logic [STALL_W-1:0]  stall_limit,
  input  logic                stall_clr,
  cr_isf_flow_ctl_if.slave    in_if,
  cr_isf_flow_ctl_if.master   out_if,
  output logic [DATA_W-1:0]   ss_cap_data,
  output logic [USER_W-1:0]   ss_cap_user,
  output logic                ss_cap_last,
  output logic                ss_cap_valid,
  output logic                ss_busy,
  output logic                halted_trig,
  output logic [1:0]          state,
  output logic                stall_event,
  output logic                stall_sts
);

  typedef enum logic [1:0] {
    ST_PASS      = 2'd0,
    ST_HALT      = 2'd1,
    ST_STEP_WAIT = 2'd2,
    ST_STEP_RUN  = 2'd3
  } state_t;

  localparam logic [SS_CNT_W-1:0] c_credit_one = {{(SS_CNT_W-1){1'b0}}, 1'b1};

  state_t               r_state, w_state_nxt;
  logic                 r_pend;
  logic                 r_halted_trig, w_halted_trig_nxt;
  logic [SS_CNT_W-1:0]  r_credit, w_credit_nxt, w_credit_load;
  logic                 r_cap_valid;
  logic [DATA_W-1:0]    r_cap_data;
  logic [USER_W-1:0]    r_cap_user;
  logic                 r_cap_last;
  logic [STALL_W-1:0]   r_stall_cnt, w_stall_cnt_nxt;
  logic                 r_stall_sts;
  logic                 w_gate, w_out_valid, w_fire, w_stall, w_stall_event;

  // A beat that was offered but not accepted keeps the gate open, so the
  // outbound valid is never withdrawn regardless of state changes.
  assign w_gate        = (r_state == ST_PASS) | (r_state == ST_STEP_RUN) | r_pend;
  assign w_out_valid   = in_if.tvalid & w_gate;
  assign w_fire        = w_out_valid & out_if.tready;
  assign w_credit_load = (ss_beats == '0) ? c_credit_one : ss_beats;

  assign out_if.tvalid = w_out_valid;
  assign out_if.tdata  = in_if.tdata;
  assign out_if.tuser  = in_if.tuser;
  assign out_if.tlast  = in_if.tlast;
  assign in_if.tready  = out_if.tready & w_gate;

  // Next-state: branches are in priority order.
  always_comb begin
    w_state_nxt       = r_state;
    w_halted_trig_nxt = r_halted_trig;
    w_credit_nxt      = r_credit;
    if (cfg_mode[1]) begin
      w_state_nxt       = ST_HALT;
      w_halted_trig_nxt = 1'b0;
    end else if (cfg_mode == 2'd1 && (r_state == ST_PASS || r_state == ST_HALT)) begin
      w_state_nxt  = ST_STEP_WAIT;
      w_credit_nxt = '0;
    end else if (cfg_mode == 2'd0 && (r_state == ST_STEP_WAIT || r_state == ST_STEP_RUN)) begin
      w_state_nxt  = ST_PASS;
      w_credit_nxt = '0;
    end else if (cfg_mode == 2'd0 && r_state == ST_HALT) begin
      if (!r_halted_trig) begin
        w_state_nxt = ST_PASS;
      end else if (resume_stb) begin
        w_state_nxt       = ST_PASS;
        w_halted_trig_nxt = 1'b0;
      end
    end else if (r_state == ST_PASS && cfg_trig_halt && trig_hit) begin
      w_state_nxt       = ST_HALT;
      w_halted_trig_nxt = 1'b1;
    end else if (r_state == ST_STEP_WAIT && ss_stb) begin
      w_state_nxt  = ST_STEP_RUN;
      w_credit_nxt = w_credit_load;
    end else if (r_state == ST_STEP_RUN && ss_stb) begin
      // Reload replaces remaining credit and overrides a same-cycle decrement.
      w_credit_nxt = w_credit_load;
    end else if (r_state == ST_STEP_RUN && w_fire && r_credit != '0) begin
      w_credit_nxt = r_credit - c_credit_one;
      if (r_credit == c_credit_one) begin
        w_state_nxt = ST_STEP_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_HALT;
      r_pend        <= 1'b0;
      r_halted_trig <= 1'b0;
      r_credit      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pend        <= w_out_valid & ~out_if.tready;
      r_halted_trig <= w_halted_trig_nxt;
      r_credit      <= w_credit_nxt;
    end
  end

  // Step capture: a beat released in STEP_RUN wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
      r_cap_user  <= '0;
      r_cap_last  <= 1'b0;
    end else if (w_fire && r_state == ST_STEP_RUN) begin
      r_cap_valid <= 1'b1;
      r_cap_data  <= in_if.tdata;
      r_cap_user  <= in_if.tuser;
      r_cap_last  <= in_if.tlast;
    end else if (ss_stb) begin
      r_cap_valid <= 1'b0;
    end
  end

  // Stall watchdog: consecutive offered-but-refused cycles, saturating.
  assign w_stall         = w_out_valid & ~out_if.tready;
  assign w_stall_cnt_nxt = !w_stall          ? '0 :
                           (&r_stall_cnt)    ? r_stall_cnt :
                                               r_stall_cnt + 1'b1;
  // Fires only on the transition into the limit; saturation keeps it single.
  assign w_stall_event   = w_stall & (stall_limit != '0) &
                           (w_stall_cnt_nxt == stall_limit) & (r_stall_cnt != stall_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_stall_sts <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
      if (w_stall_event) begin
        r_stall_sts <= 1'b1;
      end else if (stall_clr) begin
        r_stall_sts <= 1'b0;
      end
    end
  end

  assign ss_cap_data  = r_cap_data;
  assign ss_cap_user  = r_cap_user;
  assign ss_cap_last  = r_cap_last;
  assign ss_cap_valid = r_cap_valid;
  assign ss_busy      = (r_credit != '0);
  assign halted_trig  = r_halted_trig;
  assign state        = r_state;
  assign stall_event  = w_stall_event;
  assign stall_sts    = r_stall_sts;

endmodule
`default_nettype wire

// File: tb/tb_cr_isf_flow_ctl.sv
`default_nettype none
// ============================================================================
// Module : tb_cr_isf_flow_ctl
// Brief  : Self-checking bench for cr_isf_flow_ctl. A source offers numbered
//          beats, every offered beat is queued as expected output and popped
//          on each outbound handshake. Mode/step scenarios come from a vector
//          table; trigger halt, step reload, stall watchdog and reset are
//          hand-written sequences.
// Rev    : 1.0  initial release
// ============================================================================
module tb_cr_isf_flow_ctl;
  localparam int DATA_W   = 64;
  localparam int USER_W   = 8;
  localparam int SS_CNT_W = 16;
  localparam int STALL_W  = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          cfg_mode;
  logic                cfg_trig_halt, resume_stb, ss_stb, trig_hit, stall_clr;
  logic [SS_CNT_W-1:0] ss_beats;
  logic [STALL_W-1:0]  stall_limit;
  logic [DATA_W-1:0]   ss_cap_data;
  logic [USER_W-1:0]   ss_cap_user;
  logic                ss_cap_last, ss_cap_valid, ss_busy, halted_trig;
  logic [1:0]          state;
  logic                stall_event, stall_sts;

  cr_isf_flow_ctl_if #(.DATA_W(DATA_W), .USER_W(USER_W)) in_if ();
  cr_isf_flow_ctl_if #(.DATA_W(DATA_W), .USER_W(USER_W)) out_if ();

  cr_isf_flow_ctl #(.DATA_W(DATA_W), .USER_W(USER_W), .SS_CNT_W(SS_CNT_W), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_trig_halt(cfg_trig_halt),
    .resume_stb(resume_stb), .ss_stb(ss_stb), .ss_beats(ss_beats), .trig_hit(trig_hit),
    .stall_limit(stall_limit), .stall_clr(stall_clr), .in_if(in_if), .out_if(out_if),
    .ss_cap_data(ss_cap_data), .ss_cap_user(ss_cap_user), .ss_cap_last(ss_cap_last),
    .ss_cap_valid(ss_cap_valid), .ss_busy(ss_busy), .halted_trig(halted_trig),
    .state(state), .stall_event(stall_event), .stall_sts(stall_sts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [USER_W-1:0] u;
    logic              l;
  } beat_t;

  typedef struct {
    logic [1:0]  mode;
    logic        stb;
    logic [15:0] beats;
    int          offer;
    logic        rdy;
    int          cycles;
    int          exp_fires;
    logic [1:0]  exp_state;
    logic        exp_busy;
    logic        exp_cap_valid;
    int          exp_cap_idx;   // -1: capture contents not checked
  } vec_t;

  beat_t sb_q[$];
  vec_t  vt[5];
  int    n_vec = 0, n_err = 0;
  int    src_left = 0, src_idx = 0, fires = 0;
  int    stall_run = 0, ev_cnt = 0, ev_at = 0;
  bit    pushed = 1'b0, acc;

  function automatic beat_t bd(input int i);
    beat_t b;
    b.d = {32'hC0DE_0000 + 32'(i), ~32'(i)};
    b.u = 8'(i) ^ 8'h5A;
    b.l = (i % 4 == 3);
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    beat_t b;
    b = bd(src_idx);
    in_if.tvalid = (src_left > 0);
    in_if.tdata  = b.d;
    in_if.tuser  = b.u;
    in_if.tlast  = b.l;
  endtask

  task automatic add_beats(input int n);
    src_left += n;
    drive_src();
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Source + scoreboard + stall monitor. Samples at negedge, drives at +1.
  initial begin
    forever begin
      @(negedge clk);
      if (in_if.tvalid && !pushed) begin
        sb_q.push_back(bd(src_idx));
        pushed = 1'b1;
      end
      acc = in_if.tvalid && in_if.tready;
      if (in_if.tvalid)
        chk("in_tready_vs_fire", {63'd0, acc}, {63'd0, out_if.tvalid && out_if.tready});
      if (out_if.tvalid && out_if.tready) begin
        beat_t e;
        fires++;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_beat", {63'd0, out_if.tvalid}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_tdata", out_if.tdata, e.d);
          chk("sb_tuser", {56'd0, out_if.tuser}, {56'd0, e.u});
          chk("sb_tlast", {63'd0, out_if.tlast}, {63'd0, e.l});
        end
        pushed = 1'b0;
      end
      if (out_if.tvalid && !out_if.tready) stall_run++;
      else stall_run = 0;
      if (stall_event) begin
        ev_cnt++;
        ev_at = stall_run;
      end
      @(posedge clk); #1;
      if (acc) begin
        src_left--;
        src_idx++;
      end
      drive_src();
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int f0;
    beat_t b;
    vt[0] = '{2'd0, 1'b0, 16'd0,  8, 1'b1, 8, 8, 2'd0, 1'b0, 1'b0, -1};
    vt[1] = '{2'd1, 1'b0, 16'd0,  0, 1'b1, 2, 0, 2'd2, 1'b0, 1'b0, -1};
    vt[2] = '{2'd1, 1'b1, 16'd3, 10, 1'b1, 8, 3, 2'd2, 1'b0, 1'b1, 10};
    vt[3] = '{2'd1, 1'b1, 16'd0,  0, 1'b1, 4, 1, 2'd2, 1'b0, 1'b1, 11};
    vt[4] = '{2'd0, 1'b0, 16'd0,  0, 1'b1, 5, 3, 2'd0, 1'b0, 1'b1, 14};

    rst_n = 1'b1; cfg_mode = 2'd0; cfg_trig_halt = 1'b0; resume_stb = 1'b0;
    ss_stb = 1'b0; ss_beats = '0; trig_hit = 1'b0; stall_limit = '0; stall_clr = 1'b0;
    out_if.tready = 1'b0;
    drive_src();
    #1 rst_n = 1'b0;
    #12;
    chk("rst_state",      {62'd0, state}, 64'd1);
    chk("rst_out_tvalid", {63'd0, out_if.tvalid}, 64'd0);
    chk("rst_in_tready",  {63'd0, in_if.tready}, 64'd0);
    chk("rst_ss_busy",    {63'd0, ss_busy}, 64'd0);
    chk("rst_cap_valid",  {63'd0, ss_cap_valid}, 64'd0);
    chk("rst_halted",     {63'd0, halted_trig}, 64'd0);
    chk("rst_stall_sts",  {63'd0, stall_sts}, 64'd0);
    chk("rst_stall_evt",  {63'd0, stall_event}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_pass", {62'd0, state}, 64'd0);

    // Table rows 0..3, then the reload sequence, then row 4.
    for (int r = 0; r < 5; r++) begin
      if (r == 4) begin
        // ss_beats=0 step, then reload to 2 while the single credit fires.
        f0 = fires;
        ss_beats = 16'd0; ss_stb = 1'b1;
        tick();
        chk("reload_run", {62'd0, state}, 64'd3);
        ss_beats = 16'd2; ss_stb = 1'b1;
        tick();
        ss_stb = 1'b0;
        chk("reload_still_run", {62'd0, state}, 64'd3);
        chk("reload_busy", {63'd0, ss_busy}, 64'd1);
        tick(); tick();
        chk("reload_fires", 64'(fires - f0), 64'd3);
        chk("reload_state", {62'd0, state}, 64'd2);
        chk("reload_busy_end", {63'd0, ss_busy}, 64'd0);
        b = bd(14);
        chk("reload_cap", ss_cap_data, b.d);
      end
      f0 = fires;
      cfg_mode = vt[r].mode; ss_beats = vt[r].beats; ss_stb = vt[r].stb;
      out_if.tready = vt[r].rdy;
      add_beats(vt[r].offer);
      tick();
      ss_stb = 1'b0;
      for (int c = 1; c < vt[r].cycles; c++) tick();
      chk($sformatf("row%0d_fires", r), 64'(fires - f0), 64'(vt[r].exp_fires));
      chk($sformatf("row%0d_state", r), {62'd0, state}, {62'd0, vt[r].exp_state});
      chk($sformatf("row%0d_busy", r), {63'd0, ss_busy}, {63'd0, vt[r].exp_busy});
      chk($sformatf("row%0d_capv", r), {63'd0, ss_cap_valid}, {63'd0, vt[r].exp_cap_valid});
      if (vt[r].exp_cap_idx >= 0) begin
        b = bd(vt[r].exp_cap_idx);
        chk($sformatf("row%0d_cap_data", r), ss_cap_data, b.d);
        chk($sformatf("row%0d_cap_user", r), {56'd0, ss_cap_user}, {56'd0, b.u});
      end
    end

    // Trigger halt under a refused beat: beat must stay valid until taken.
    f0 = fires;
    out_if.tready = 1'b0; cfg_trig_halt = 1'b1;
    add_beats(2);
    tick();
    trig_hit = 1'b1;
    tick();
    trig_hit = 1'b0;
    b = bd(18);
    chk("trig_state", {62'd0, state}, 64'd1);
    chk("trig_halted", {63'd0, halted_trig}, 64'd1);
    chk("trig_hold_valid", {63'd0, out_if.tvalid}, 64'd1);
    chk("trig_hold_data", out_if.tdata, b.d);
    out_if.tready = 1'b1;
    tick();
    chk("trig_gate_closed", {63'd0, out_if.tvalid}, 64'd0);
    chk("trig_one_fire", 64'(fires - f0), 64'd1);
    tick(); tick(); tick();
    chk("trig_stays_halt", {62'd0, state}, 64'd1);
    resume_stb = 1'b1;
    tick();
    resume_stb = 1'b0;
    chk("resume_state", {62'd0, state}, 64'd0);
    chk("resume_halted", {63'd0, halted_trig}, 64'd0);
    tick(); tick();
    chk("resume_fires", 64'(fires - f0), 64'd2);
    cfg_trig_halt = 1'b0;

    // Stall watchdog.
    stall_limit = 32'd5; out_if.tready = 1'b0; ev_cnt = 0; ev_at = 0;
    add_beats(1);
    for (int c = 0; c < 12; c++) tick();
    chk("stall_ev_count", 64'(ev_cnt), 64'd1);
    chk("stall_ev_cycle", 64'(ev_at), 64'd5);
    chk("stall_sts_set", {63'd0, stall_sts}, 64'd1);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("stall_sts_clr", {63'd0, stall_sts}, 64'd0);
    out_if.tready = 1'b1;
    tick(); tick();

    // Reset asserted in STEP_RUN with credit 7 and a capture held.
    cfg_mode = 2'd1; out_if.tready = 1'b0;
    tick(); tick();
    add_beats(2);
    ss_beats = 16'd8; ss_stb = 1'b1;
    tick();
    ss_stb = 1'b0; out_if.tready = 1'b1;
    tick();
    out_if.tready = 1'b0;
    b = bd(21);
    chk("pre_rst_state", {62'd0, state}, 64'd3);
    chk("pre_rst_busy", {63'd0, ss_busy}, 64'd1);
    chk("pre_rst_capv", {63'd0, ss_cap_valid}, 64'd1);
    chk("pre_rst_cap", ss_cap_data, b.d);
    rst_n = 1'b0;
    #1;
    chk("arst_state", {62'd0, state}, 64'd1);
    chk("arst_out_tvalid", {63'd0, out_if.tvalid}, 64'd0);
    chk("arst_in_tready", {63'd0, in_if.tready}, 64'd0);
    chk("arst_busy", {63'd0, ss_busy}, 64'd0);
    chk("arst_capv", {63'd0, ss_cap_valid}, 64'd0);
    sb_q.delete(); pushed = 1'b0; src_left = 0; drive_src();
    cfg_mode = 2'd0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rerst_pass", {62'd0, state}, 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
